// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with occupancy count, level thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered RDATA.
module fifo_sync_param #(
   parameter int DSIZE    = 16,
   parameter int ASIZE    = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [DSIZE-1:0] WDATA,
   input  logic             WINC,
   input  logic             RINC,
   output logic [DSIZE-1:0] RDATA,
   output logic             REMPTY,
   output logic             WFULL,
   output logic             AEMPTY,
   output logic             AFULL,
   output logic [ASIZE:0]   COUNT,
   output logic             OVF,
   output logic             UDF
);
   localparam int DEPTH = 1 << ASIZE;
   logic [DSIZE-1:0] mem_q [DEPTH];
   logic [ASIZE-1:0] wptr_q, rptr_q;
   logic [ASIZE:0]   count_q, count_d;
   logic             ovf_q, udf_q, wr_ok, rd_ok;
   assign REMPTY = count_q == '0;
   assign WFULL  = count_q == (ASIZE+1)'(DEPTH);
   assign AFULL  = count_q >= (ASIZE+1)'(AF_LEVEL);
   assign AEMPTY = count_q <= (ASIZE+1)'(AE_LEVEL);
   assign COUNT  = count_q;
   assign OVF    = ovf_q;
   assign UDF    = udf_q;
   // A read frees a slot in the same edge, so a full FIFO still accepts a paired write.
   assign rd_ok   = RINC & ~REMPTY;
   assign wr_ok   = WINC & (~WFULL | rd_ok);
   assign count_d = count_q + {{ASIZE{1'b0}}, wr_ok} - {{ASIZE{1'b0}}, rd_ok};
   always_ff @(posedge CLK) begin
      if (wr_ok) mem_q[wptr_q] <= WDATA;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wr_ok ? wptr_q + 1'b1 : wptr_q;
         rptr_q  <= rd_ok ? rptr_q + 1'b1 : rptr_q;
         count_q <= count_d;
         ovf_q   <= ovf_q | (WINC & WFULL & ~rd_ok);
         udf_q   <= udf_q | (RINC & REMPTY);
      end
   end
`ifdef FIFO_FWFT_EN
   assign RDATA = mem_q[rptr_q];
`else
   logic [DSIZE-1:0] rdata_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) rdata_q <= '0;
      else if (rd_ok) rdata_q <= mem_q[rptr_q];
   end
   assign RDATA = rdata_q;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed stimulus against a queue-based FIFO model, checked every cycle.
// Build with FIFO_FWFT_EN defined to exercise first-word-fall-through reads.
module tb_fifo_sync_param;
   localparam int DEPTH = 16;
   logic        CLK = 0, RST = 1, WINC = 0, RINC = 0;
   logic [15:0] WDATA = '0, RDATA;
   logic        REMPTY, WFULL, AEMPTY, AFULL, OVF, UDF;
   logic [4:0]  COUNT;
   int          checks = 0, failures = 0;
   logic [15:0] mq[$];
   logic [15:0] m_rdata = '0;
   logic        m_ovf = 0, m_udf = 0;

   fifo_sync_param dut (
      .CLK(CLK), .RST(RST), .WDATA(WDATA), .WINC(WINC), .RINC(RINC),
      .RDATA(RDATA), .REMPTY(REMPTY), .WFULL(WFULL), .AEMPTY(AEMPTY),
      .AFULL(AFULL), .COUNT(COUNT), .OVF(OVF), .UDF(UDF)
   );

   initial forever #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         mq.delete();
         m_rdata = '0;
         m_ovf = 0;
         m_udf = 0;
      end else begin
         automatic bit rd = RINC && mq.size() > 0;
         automatic bit wr = WINC && (mq.size() < DEPTH || rd);
         if (WINC && mq.size() == DEPTH && !rd) m_ovf = 1;
         if (RINC && mq.size() == 0) m_udf = 1;
         if (rd) m_rdata = mq.pop_front();
         if (wr) mq.push_back(WDATA);
      end
   end

   always @(negedge CLK) begin
      automatic int n = mq.size();
      chk("count", 32'(COUNT), 32'(n));
      chk("rempty", 32'(REMPTY), 32'(n == 0));
      chk("wfull", 32'(WFULL), 32'(n == DEPTH));
      chk("afull", 32'(AFULL), 32'(n >= 12));
      chk("aempty", 32'(AEMPTY), 32'(n <= 4));
      chk("ovf", 32'(OVF), 32'(m_ovf));
      chk("udf", 32'(UDF), 32'(m_udf));
`ifdef FIFO_FWFT_EN
      if (n > 0) chk("rdata_head", 32'(RDATA), 32'(mq[0]));
`else
      chk("rdata", 32'(RDATA), 32'(m_rdata));
`endif
   end

   task automatic step(input logic w, input logic r, input logic [15:0] d);
      WINC = w;
      RINC = r;
      WDATA = d;
      @(posedge CLK);
      #1;
      WINC = 0;
      RINC = 0;
   endtask

   // Std mode: checks the word loaded by the read. FWFT: checks the head before the pop.
   task automatic read_expect(input string name, input logic [15:0] exp);
`ifdef FIFO_FWFT_EN
      chk(name, 32'(RDATA), 32'(exp));
      step(0, 1, '0);
`else
      step(0, 1, '0);
      chk(name, 32'(RDATA), 32'(exp));
`endif
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1 RST = 0;
      chk("rst_count", 32'(COUNT), 0);
      chk("rst_rempty", 32'(REMPTY), 1);
      chk("rst_aempty", 32'(AEMPTY), 1);
      for (int i = 1; i <= 16; i++) begin
         step(1, 0, 16'(i));
         chk("fill_count", 32'(COUNT), 32'(i));
         chk("fill_aempty", 32'(AEMPTY), 32'(i <= 4));
         chk("fill_afull", 32'(AFULL), 32'(i >= 12));
         chk("fill_wfull", 32'(WFULL), 32'(i == 16));
      end
`ifdef FIFO_FWFT_EN
      chk("full_head", 32'(RDATA), 32'h0001);
`endif
      step(1, 1, 16'hBEEF);
      chk("fullrw_count", 32'(COUNT), 16);
      chk("fullrw_ovf", 32'(OVF), 0);
`ifndef FIFO_FWFT_EN
      chk("fullrw_rdata", 32'(RDATA), 32'h0001);
`endif
      step(1, 0, 16'hDEAD);
      chk("ovf_flag", 32'(OVF), 1);
      chk("ovf_count", 32'(COUNT), 16);
      for (int i = 2; i <= 16; i++) read_expect("drain", 16'(i));
      read_expect("drain_last", 16'hBEEF);
      chk("drain_empty", 32'(REMPTY), 1);
      step(1, 1, 16'h00AA);
      chk("udf_flag", 32'(UDF), 1);
      chk("udf_count", 32'(COUNT), 1);
      read_expect("udf_read", 16'h00AA);
      chk("udf_after_count", 32'(COUNT), 0);
      for (int i = 0; i < 5; i++) step(1, 0, 16'h0050 + 16'(i));
      chk("pre_rst_count", 32'(COUNT), 5);
      #2 RST = 1;
      #1;
      chk("arst_count", 32'(COUNT), 0);
      chk("arst_rempty", 32'(REMPTY), 1);
      chk("arst_aempty", 32'(AEMPTY), 1);
      chk("arst_wfull", 32'(WFULL), 0);
      chk("arst_afull", 32'(AFULL), 0);
      chk("arst_ovf", 32'(OVF), 0);
      chk("arst_udf", 32'(UDF), 0);
`ifndef FIFO_FWFT_EN
      chk("arst_rdata", 32'(RDATA), 0);
`endif
      @(posedge CLK);
      #1 RST = 0;
      for (int i = 0; i < 3; i++) step(1, 0, 16'h0100 + 16'(i));
      for (int i = 0; i < 40; i++) begin
`ifdef FIFO_FWFT_EN
         chk("wrap_head", 32'(RDATA), 32'h0100 + 32'(i));
         step(1, 1, 16'h0103 + 16'(i));
`else
         step(1, 1, 16'h0103 + 16'(i));
         chk("wrap_rdata", 32'(RDATA), 32'h0100 + 32'(i));
`endif
         chk("wrap_count", 32'(COUNT), 3);
      end
      repeat (2) @(posedge CLK);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
